// File: rtl/mc_ctrl.sv
// mc_ctrl - multi-cycle control sequencer for an RV32I core.
//
// Steps each instruction through START/FETCH/DECODE/EXEC/MEM/WB. It drives
// the PC, IR, ALU, register-file and data-memory enables and selects from the
// current state, the IR opcode and the memory acks. Each instruction- or
// data-memory request is bounded by a timeout. An unsupported opcode or a
// timeout parks the sequencer in FAULT until reset.
//
// Ports:
//   i_clk, i_rst_n      clock (rising edge), asynchronous active-low reset
//   i_inst              current IR contents, opcode = i_inst[6:0]
//   i_imem_ack          instruction memory ack (IR data valid this cycle)
//   i_dmem_ack          data memory ack (load data valid / store done)
//   i_br_taken          branch comparator result, used in EXEC
//   o_imem_req, o_ir_we instruction fetch request / IR load
//   o_dmem_req, o_dmem_we data memory request / write (store)
//   o_pc_we, o_pc_sel   PC update and source (0=PC+4, 1=PC+imm, 2=ALU&~1)
//   o_alu_a_sel         ALU A: 0=rs1, 1=PC
//   o_alu_b_sel         ALU B: 0=rs2, 1=imm
//   o_rf_we, o_wb_sel   register write and source (0=ALU,1=load,2=PC+4,3=imm)
//   o_fault, o_fault_code  sticky fault flag and cause (01=timeout, 10=illegal)
//   o_state             current state, for debug
module mc_ctrl #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_inst,
  input  logic        i_imem_ack,
  input  logic        i_dmem_ack,
  input  logic        i_br_taken,
  output logic        o_imem_req,
  output logic        o_ir_we,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic        o_pc_we,
  output logic [1:0]  o_pc_sel,
  output logic        o_alu_a_sel,
  output logic        o_alu_b_sel,
  output logic        o_rf_we,
  output logic [1:0]  o_wb_sel,
  output logic        o_fault,
  output logic [1:0]  o_fault_code,
  output logic [2:0]  o_state
);

  typedef enum logic [2:0] {
    ST_START  = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_FAULT  = 3'd7
  } state_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [1:0] FC_TIMEOUT = 2'b01;
  localparam logic [1:0] FC_ILLEGAL = 2'b10;

  localparam int            CW    = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    fault_code;

  logic [6:0] opcode;
  logic is_op, is_imm, is_load, is_store, is_branch;
  logic is_jal, is_jalr, is_lui, is_auipc, is_legal;

  // Only the opcode field steers the sequencer; operand fields go elsewhere.
  logic unused_inst;
  assign unused_inst = ^i_inst[31:7];

  assign opcode    = i_inst[6:0];
  assign is_op     = (opcode == OPC_OP);
  assign is_imm    = (opcode == OPC_IMM);
  assign is_load   = (opcode == OPC_LOAD);
  assign is_store  = (opcode == OPC_STORE);
  assign is_branch = (opcode == OPC_BRANCH);
  assign is_jal    = (opcode == OPC_JAL);
  assign is_jalr   = (opcode == OPC_JALR);
  assign is_lui    = (opcode == OPC_LUI);
  assign is_auipc  = (opcode == OPC_AUIPC);
  assign is_legal  = is_op | is_imm | is_load | is_store | is_branch |
                     is_jal | is_jalr | is_lui | is_auipc;

  // State, timeout counter and fault cause. The counter is cleared on every
  // state change, so it only counts consecutive un-acked cycles of one request.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= ST_START;
      cnt        <= '0;
      fault_code <= 2'b00;
    end else begin
      case (state)
        ST_START: begin
          state <= ST_FETCH;
          cnt   <= '0;
        end
        ST_FETCH: begin
          // An ack in the limit cycle wins over the timeout.
          if (i_imem_ack) begin
            state <= ST_DECODE;
            cnt   <= '0;
          end else if (cnt == LIMIT) begin
            state      <= ST_FAULT;
            fault_code <= FC_TIMEOUT;
            cnt        <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_DECODE: begin
          cnt <= '0;
          if (is_legal) begin
            state <= ST_EXEC;
          end else begin
            state      <= ST_FAULT;
            fault_code <= FC_ILLEGAL;
          end
        end
        ST_EXEC: begin
          cnt <= '0;
          if (is_branch || is_jal || is_jalr) begin
            state <= ST_FETCH;
          end else if (is_load || is_store) begin
            state <= ST_MEM;
          end else if (is_legal) begin
            state <= ST_WB;
          end else begin
            // IR changed under us after DECODE; treat it as illegal.
            state      <= ST_FAULT;
            fault_code <= FC_ILLEGAL;
          end
        end
        ST_MEM: begin
          if (i_dmem_ack) begin
            state <= is_store ? ST_FETCH : ST_WB;
            cnt   <= '0;
          end else if (cnt == LIMIT) begin
            state      <= ST_FAULT;
            fault_code <= FC_TIMEOUT;
            cnt        <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_WB: begin
          state <= ST_FETCH;
          cnt   <= '0;
        end
        ST_FAULT: begin
          state <= ST_FAULT;
          cnt   <= '0;
        end
        default: begin
          state <= ST_START;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Control outputs are decoded from state, opcode and acks so that IR load
  // and store completion land in the same cycle as the ack.
  // NOTE: every output gets a default before the case, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    o_imem_req  = 1'b0;
    o_ir_we     = 1'b0;
    o_dmem_req  = 1'b0;
    o_dmem_we   = 1'b0;
    o_pc_we     = 1'b0;
    o_pc_sel    = 2'd0;
    o_alu_a_sel = 1'b0;
    o_alu_b_sel = 1'b0;
    o_rf_we     = 1'b0;
    o_wb_sel    = 2'd0;
    case (state)
      ST_FETCH: begin
        o_imem_req = 1'b1;
        o_ir_we    = i_imem_ack;
      end
      ST_EXEC: begin
        if (is_branch) begin
          o_pc_we  = 1'b1;
          o_pc_sel = i_br_taken ? 2'd1 : 2'd0;
        end else if (is_jal) begin
          o_pc_we  = 1'b1;
          o_pc_sel = 2'd1;
          o_rf_we  = 1'b1;
          o_wb_sel = 2'd2;
        end else if (is_jalr) begin
          // PC and rd are written on the same edge, so the ALU still sees
          // the old rs1 even when rd == rs1.
          o_alu_b_sel = 1'b1;
          o_pc_we     = 1'b1;
          o_pc_sel    = 2'd2;
          o_rf_we     = 1'b1;
          o_wb_sel    = 2'd2;
        end else if (is_load || is_store || is_imm) begin
          o_alu_b_sel = 1'b1;
        end else if (is_auipc) begin
          o_alu_a_sel = 1'b1;
          o_alu_b_sel = 1'b1;
        end
      end
      ST_MEM: begin
        // Keep the address (rs1 + imm) on the ALU output while waiting.
        o_dmem_req  = 1'b1;
        o_alu_b_sel = 1'b1;
        o_dmem_we   = is_store;
        if (i_dmem_ack && is_store) begin
          o_pc_we  = 1'b1;
          o_pc_sel = 2'd0;
        end
      end
      ST_WB: begin
        // Operand selects repeat the EXEC values so the ALU result is stable.
        o_rf_we     = 1'b1;
        o_pc_we     = 1'b1;
        o_pc_sel    = 2'd0;
        o_alu_a_sel = is_auipc;
        o_alu_b_sel = is_imm | is_auipc | is_load;
        o_wb_sel    = is_load ? 2'd1 : (is_lui ? 2'd3 : 2'd0);
      end
      default: ;
    endcase
  end

  assign o_fault      = (state == ST_FAULT);
  assign o_fault_code = fault_code;
  assign o_state      = state;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl - self-checking bench for mc_ctrl.
//
// Each instruction's expected per-cycle output trace is built from the
// sequencer's rules: the instruction class, the ack delays and the branch
// outcome. The bench compares the whole output bundle every cycle. Acks that
// the sequencer should ignore are driven randomly.
module tb_mc_ctrl;

  localparam int TO = 16;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b1;
  logic [31:0] i_inst = 32'h0;
  logic        i_imem_ack = 1'b0;
  logic        i_dmem_ack = 1'b0;
  logic        i_br_taken = 1'b0;
  logic        o_imem_req, o_ir_we, o_dmem_req, o_dmem_we, o_pc_we;
  logic [1:0]  o_pc_sel;
  logic        o_alu_a_sel, o_alu_b_sel, o_rf_we;
  logic [1:0]  o_wb_sel;
  logic        o_fault;
  logic [1:0]  o_fault_code;
  logic [2:0]  o_state;

  mc_ctrl #(.MEM_TIMEOUT(TO)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_inst(i_inst),
    .i_imem_ack(i_imem_ack), .i_dmem_ack(i_dmem_ack), .i_br_taken(i_br_taken),
    .o_imem_req(o_imem_req), .o_ir_we(o_ir_we), .o_dmem_req(o_dmem_req),
    .o_dmem_we(o_dmem_we), .o_pc_we(o_pc_we), .o_pc_sel(o_pc_sel),
    .o_alu_a_sel(o_alu_a_sel), .o_alu_b_sel(o_alu_b_sel), .o_rf_we(o_rf_we),
    .o_wb_sel(o_wb_sel), .o_fault(o_fault), .o_fault_code(o_fault_code),
    .o_state(o_state)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [2:0] st;
    logic       imem_req;
    logic       ir_we;
    logic       dmem_req;
    logic       dmem_we;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       alu_a;
    logic       alu_b;
    logic       rf_we;
    logic [1:0] wb_sel;
    logic       fault;
    logic [1:0] code;
  } obs_t;

  obs_t obs;
  assign obs = {o_state, o_imem_req, o_ir_we, o_dmem_req, o_dmem_we, o_pc_we,
                o_pc_sel, o_alu_a_sel, o_alu_b_sel, o_rf_we, o_wb_sel,
                o_fault, o_fault_code};

  typedef enum {C_OP, C_IMM, C_LD, C_ST, C_BR, C_JAL, C_JALR, C_LUI, C_AUIPC, C_ILL} cls_t;

  int total = 0;
  int bad   = 0;

  function automatic cls_t cls_of(input logic [6:0] opc);
    case (opc)
      7'b0110011: return C_OP;
      7'b0010011: return C_IMM;
      7'b0000011: return C_LD;
      7'b0100011: return C_ST;
      7'b1100011: return C_BR;
      7'b1101111: return C_JAL;
      7'b1100111: return C_JALR;
      7'b0110111: return C_LUI;
      7'b0010111: return C_AUIPC;
      default:    return C_ILL;
    endcase
  endfunction

  function automatic obs_t idle(input logic [2:0] st);
    obs_t e;
    e    = '0;
    e.st = st;
    return e;
  endfunction

  task automatic check(input string tag, input obs_t e);
    total++;
    assert (obs === e) else begin
      bad++;
      $error("FAIL %s: got %h want %h (state got %0d want %0d)", tag, obs, e, obs.st, e.st);
    end
  endtask

  // One clock cycle: called at posedge+1, drives acks, checks at negedge,
  // returns at the next posedge+1.
  task automatic cyc(input string tag, input obs_t e, input logic ia, input logic da);
    i_imem_ack = ia;
    i_dmem_ack = da;
    @(negedge i_clk);
    check(tag, e);
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic fault_cycles(input logic [1:0] code, input int n);
    obs_t e;
    for (int k = 0; k < n; k++) begin
      e       = idle(3'd7);
      e.fault = 1'b1;
      e.code  = code;
      i_br_taken = rnd();
      cyc("fault", e, rnd(), rnd());
    end
  endtask

  // Runs one instruction from the first FETCH cycle. di/dd are the number of
  // wait cycles before the imem/dmem ack; a value >= TO means no ack at all.
  task automatic run_instr(input logic [31:0] inst, input logic br, input int di, input int dd);
    obs_t e;
    cls_t c;
    logic ack;
    c = cls_of(inst[6:0]);
    i_inst     = inst;
    i_br_taken = br;
    for (int k = 0; k < TO && k <= di; k++) begin
      ack        = (k == di);
      e          = idle(3'd1);
      e.imem_req = 1'b1;
      e.ir_we    = ack;
      cyc("fetch", e, ack, rnd());
    end
    if (di >= TO) begin
      fault_cycles(2'b01, 3);
      return;
    end
    cyc("decode", idle(3'd2), rnd(), rnd());
    if (c == C_ILL) begin
      fault_cycles(2'b10, 4);
      return;
    end
    e = idle(3'd3);
    case (c)
      C_BR:    begin e.pc_we = 1; e.pc_sel = br ? 2'd1 : 2'd0; end
      C_JAL:   begin e.pc_we = 1; e.pc_sel = 2'd1; e.rf_we = 1; e.wb_sel = 2'd2; end
      C_JALR:  begin e.alu_b = 1; e.pc_we = 1; e.pc_sel = 2'd2; e.rf_we = 1; e.wb_sel = 2'd2; end
      C_LD, C_ST, C_IMM: e.alu_b = 1;
      C_AUIPC: begin e.alu_a = 1; e.alu_b = 1; end
      default: ;
    endcase
    cyc("exec", e, rnd(), rnd());
    if (c == C_BR || c == C_JAL || c == C_JALR) return;
    if (c == C_LD || c == C_ST) begin
      for (int k = 0; k < TO && k <= dd; k++) begin
        ack        = (k == dd);
        e          = idle(3'd4);
        e.dmem_req = 1'b1;
        e.alu_b    = 1'b1;
        e.dmem_we  = (c == C_ST);
        e.pc_we    = ack && (c == C_ST);
        cyc("mem", e, rnd(), ack);
      end
      if (dd >= TO) begin
        fault_cycles(2'b01, 3);
        return;
      end
      if (c == C_ST) return;
    end
    e        = idle(3'd5);
    e.rf_we  = 1'b1;
    e.pc_we  = 1'b1;
    e.alu_a  = (c == C_AUIPC);
    e.alu_b  = (c == C_IMM) || (c == C_AUIPC) || (c == C_LD);
    e.wb_sel = (c == C_LD) ? 2'd1 : ((c == C_LUI) ? 2'd3 : 2'd0);
    cyc("wb", e, rnd(), rnd());
  endtask

  // Asserts reset asynchronously, releases it and leaves the DUT in FETCH.
  task automatic do_reset();
    i_rst_n = 1'b0;
    #1;
    check("rst_async", idle(3'd0));
    i_imem_ack = 1'b1;
    i_dmem_ack = 1'b1;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    check("rst_hold", idle(3'd0));
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    i_imem_ack = 1'b0;
    i_dmem_ack = 1'b0;
    @(negedge i_clk);
    check("start", idle(3'd0));
    @(posedge i_clk);
    #1;
  endtask

  logic [6:0] legal_opc [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
                                7'b0010111};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    obs_t e;
    logic [31:0] inst;
    #2;
    do_reset();

    // Directed instructions with zero-wait or small delays.
    run_instr(32'h00500093, 1'b0, 0, 0);   // ADDI
    run_instr(32'h0000A103, 1'b0, 0, 3);   // LW, MEM lasts 4 cycles
    run_instr(32'h00000063, 1'b1, 0, 0);   // BEQ taken
    run_instr(32'h00000063, 1'b0, 1, 0);   // BEQ not taken
    run_instr(32'h0000006F, 1'b0, 0, 0);   // JAL
    run_instr(32'h00008067, 1'b1, 2, 0);   // JALR
    run_instr(32'h00112023, 1'b0, 0, 2);   // SW
    run_instr(32'h123450B7, 1'b0, 0, 0);   // LUI
    run_instr(32'h00001097, 1'b0, 0, 0);   // AUIPC
    run_instr(32'h002081B3, 1'b0, 0, 0);   // ADD

    // Ack in the last allowed cycle of each request: no fault.
    run_instr(32'h00500093, 1'b0, TO - 1, 0);
    run_instr(32'h0000A103, 1'b0, 0, TO - 1);

    // Randomized legal instructions.
    for (int n = 0; n < 60; n++) begin
      inst = ($urandom() & 32'hFFFF_FF80) | {25'd0, legal_opc[$urandom_range(0, 8)]};
      run_instr(inst, rnd(), $urandom_range(0, 4), $urandom_range(0, 4));
    end

    // Illegal opcode: fault code 10 until reset.
    run_instr(32'h0000007F, 1'b0, 0, 0);
    do_reset();
    run_instr(32'h00500093, 1'b0, 0, 0);

    // Instruction fetch timeout after exactly TO cycles.
    run_instr(32'h00500093, 1'b0, TO, 0);
    do_reset();

    // Data memory timeout on a store.
    run_instr(32'h00112023, 1'b0, 0, TO);
    do_reset();

    // Reset in the middle of MEM: outputs drop to zero immediately.
    i_inst = 32'h0000A103;
    e = idle(3'd1); e.imem_req = 1; e.ir_we = 1;
    cyc("mr_fetch", e, 1'b1, 1'b0);
    cyc("mr_decode", idle(3'd2), 1'b0, 1'b0);
    e = idle(3'd3); e.alu_b = 1;
    cyc("mr_exec", e, 1'b0, 1'b0);
    e = idle(3'd4); e.dmem_req = 1; e.alu_b = 1;
    cyc("mr_mem", e, 1'b0, 1'b0);
    i_dmem_ack = 1'b1;
    do_reset();
    run_instr(32'h0000A103, 1'b0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
